// File: rtl/cdc_rx_check.sv
// Destination-domain receive checker: registers a CDC word, debounces it,
// and flags words that do not advance by exactly one (mod 16).
//
// Ports:
//   CLK3       in   destination-domain clock
//   RST        in   asynchronous active-high reset
//   ODATA      in   [3:0] word from the synchronizer stage (may glitch)
//   DOUT       out  [3:0] last accepted word
//   DVALID     out  one-cycle pulse when DOUT takes a new accepted value
//   SEQ_ERR    out  one-cycle pulse with DVALID when word != previous+1
//   CHG_CNT    out  [CNT_W-1:0] accepted changes (baseline excluded), sat.
//   ERR_CNT    out  [CNT_W-1:0] SEQ_ERR pulses, saturating
//   GLITCH_CNT out  [CNT_W-1:0] rejected candidates, saturating
module cdc_rx_check #(
   parameter int STABLE_CNT = 2,
   parameter int CNT_W      = 8
) (
   input  logic             CLK3,
   input  logic             RST,
   input  logic [3:0]       ODATA,
   output logic [3:0]       DOUT,
   output logic             DVALID,
   output logic             SEQ_ERR,
   output logic [CNT_W-1:0] CHG_CNT,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CNT_W-1:0] GLITCH_CNT
);

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      STABLE = 2'd1,
      FILTER = 2'd2
   } state_t;

   localparam logic [3:0]       HMAX = 4'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t     state, state_n;
   logic [3:0] din_q;
   logic       din_vld;
   logic [3:0] cand, cand_n;
   logic [3:0] hits, hits_n;
   logic [3:0] dout_n;
   logic       dvalid_n;
   logic       seq_n;
   logic       chg_inc;
   logic       err_inc;
   logic       gl_inc;
   logic [3:0] dout_inc;
   logic       seq_bad;

   assign dout_inc = DOUT + 4'd1;
   assign seq_bad  = (cand != dout_inc);

   // din_vld marks that din_q holds a captured sample rather than its
   // reset value, so the first post-reset edge never seeds the filter.
   always_comb begin
      state_n  = state;
      cand_n   = cand;
      hits_n   = hits;
      dout_n   = DOUT;
      dvalid_n = 1'b0;
      seq_n    = 1'b0;
      chg_inc  = 1'b0;
      err_inc  = 1'b0;
      gl_inc   = 1'b0;
      unique case (state)
         INIT: begin
            if (din_vld) begin
               if (hits != 4'd0 && din_q == cand) begin
                  if (hits >= HMAX) begin
                     dout_n   = cand;
                     dvalid_n = 1'b1;
                     state_n  = STABLE;
                  end else begin
                     hits_n = hits + 4'd1;
                  end
               end else begin
                  cand_n = din_q;
                  hits_n = 4'd1;
               end
            end
         end
         STABLE: begin
            if (din_q != DOUT) begin
               cand_n  = din_q;
               hits_n  = 4'd1;
               state_n = FILTER;
            end
         end
         FILTER: begin
            if (din_q == cand) begin
               if (hits >= HMAX) begin
                  dout_n   = cand;
                  dvalid_n = 1'b1;
                  seq_n    = seq_bad;
                  chg_inc  = 1'b1;
                  err_inc  = seq_bad;
                  state_n  = STABLE;
               end else begin
                  hits_n = hits + 4'd1;
               end
            end else if (din_q == DOUT) begin
               gl_inc  = 1'b1;
               state_n = STABLE;
            end else begin
               gl_inc = 1'b1;
               cand_n = din_q;
               hits_n = 4'd1;
            end
         end
         default: state_n = INIT;
      endcase
   end

   always_ff @(posedge CLK3 or posedge RST) begin
      if (RST) begin
         state      <= INIT;
         din_q      <= 4'd0;
         din_vld    <= 1'b0;
         cand       <= 4'd0;
         hits       <= 4'd0;
         DOUT       <= 4'd0;
         DVALID     <= 1'b0;
         SEQ_ERR    <= 1'b0;
         CHG_CNT    <= '0;
         ERR_CNT    <= '0;
         GLITCH_CNT <= '0;
      end else begin
         state   <= state_n;
         din_q   <= ODATA;
         din_vld <= 1'b1;
         cand    <= cand_n;
         hits    <= hits_n;
         DOUT    <= dout_n;
         DVALID  <= dvalid_n;
         SEQ_ERR <= seq_n;
         if (chg_inc && CHG_CNT != '1)
            CHG_CNT <= CHG_CNT + ONE;
         if (err_inc && ERR_CNT != '1)
            ERR_CNT <= ERR_CNT + ONE;
         if (gl_inc && GLITCH_CNT != '1)
            GLITCH_CNT <= GLITCH_CNT + ONE;
      end
   end

endmodule

// File: tb/tb_cdc_rx_check.sv
// Directed bench for cdc_rx_check: table of per-cycle vectors plus
// hand-written stepping, saturation and mid-filter reset sequences.
module tb_cdc_rx_check;

   logic       CLK3 = 1'b0;
   logic       RST  = 1'b1;
   logic [3:0] ODATA = 4'd0;

   logic [3:0] DOUT, DOUT3;
   logic       DVALID, SEQ_ERR, DVALID3, SEQ_ERR3;
   logic [7:0] CHG_CNT, ERR_CNT, GLITCH_CNT;
   logic [3:0] CHG3, ERR3, GL3;

   int checks   = 0;
   int failures = 0;

   always #14 CLK3 = ~CLK3;

   cdc_rx_check #(.STABLE_CNT(2), .CNT_W(8)) u_dut (
      .CLK3(CLK3), .RST(RST), .ODATA(ODATA),
      .DOUT(DOUT), .DVALID(DVALID), .SEQ_ERR(SEQ_ERR),
      .CHG_CNT(CHG_CNT), .ERR_CNT(ERR_CNT),
      .GLITCH_CNT(GLITCH_CNT)
   );

   cdc_rx_check #(.STABLE_CNT(3), .CNT_W(4)) u_dut3 (
      .CLK3(CLK3), .RST(RST), .ODATA(ODATA),
      .DOUT(DOUT3), .DVALID(DVALID3), .SEQ_ERR(SEQ_ERR3),
      .CHG_CNT(CHG3), .ERR_CNT(ERR3),
      .GLITCH_CNT(GL3)
   );

   typedef struct {
      logic [3:0] od;
      logic [3:0] dout;
      logic       dv;
      logic       se;
      logic [7:0] chg;
      logic [7:0] err;
      logic [7:0] gl;
      logic [3:0] dout3;
      logic       dv3;
   } vec_t;

   vec_t tbl [0:21];

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK3);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] v);
      ODATA = v;
      RST   = 1'b1;
      tick();
      tick();
      chk("rst dout",   8'(DOUT), 8'h0);
      chk("rst dvalid", 8'(DVALID), 8'h0);
      chk("rst seq",    8'(SEQ_ERR), 8'h0);
      chk("rst chg",    CHG_CNT, 8'h0);
      chk("rst err",    ERR_CNT, 8'h0);
      chk("rst glitch", GLITCH_CNT, 8'h0);
      RST = 1'b0;
   endtask

   int         p1, p3, se;
   logic [3:0] v;

   initial begin
      //        od    dout  dv    se    chg   err   gl    dout3 dv3
      tbl[0]  = '{4'h3, 4'h0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b0};
      tbl[1]  = '{4'h3, 4'h0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b0};
      tbl[2]  = '{4'h3, 4'h3, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b0};
      tbl[3]  = '{4'h3, 4'h3, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h3, 1'b1};
      tbl[4]  = '{4'h4, 4'h3, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h3, 1'b0};
      tbl[5]  = '{4'h4, 4'h3, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h3, 1'b0};
      tbl[6]  = '{4'h4, 4'h4, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 4'h3, 1'b0};
      tbl[7]  = '{4'h4, 4'h4, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h4, 1'b1};
      tbl[8]  = '{4'h7, 4'h4, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h4, 1'b0};
      tbl[9]  = '{4'h7, 4'h4, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h4, 1'b0};
      tbl[10] = '{4'h7, 4'h7, 1'b1, 1'b1, 8'd2, 8'd1, 8'd0, 4'h4, 1'b0};
      tbl[11] = '{4'h7, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd0, 4'h7, 1'b1};
      tbl[12] = '{4'hA, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd0, 4'h7, 1'b0};
      tbl[13] = '{4'h7, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd0, 4'h7, 1'b0};
      tbl[14] = '{4'h7, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd1, 4'h7, 1'b0};
      tbl[15] = '{4'h7, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd1, 4'h7, 1'b0};
      tbl[16] = '{4'h8, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd1, 4'h7, 1'b0};
      tbl[17] = '{4'hC, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd1, 4'h7, 1'b0};
      tbl[18] = '{4'h8, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd2, 4'h7, 1'b0};
      tbl[19] = '{4'h8, 4'h7, 1'b0, 1'b0, 8'd2, 8'd1, 8'd3, 4'h7, 1'b0};
      tbl[20] = '{4'h8, 4'h8, 1'b1, 1'b0, 8'd3, 8'd1, 8'd3, 4'h7, 1'b0};
      tbl[21] = '{4'h8, 4'h8, 1'b0, 1'b0, 8'd3, 8'd1, 8'd3, 4'h8, 1'b1};

      // Table: baseline latency, normal step, seq error, glitches
      do_reset(4'h3);
      for (int i = 0; i < 22; i++) begin
         ODATA = tbl[i].od;
         tick();
         chk($sformatf("r%0d dout", i), 8'(DOUT), 8'(tbl[i].dout));
         chk($sformatf("r%0d dvalid", i), 8'(DVALID), 8'(tbl[i].dv));
         chk($sformatf("r%0d seq", i), 8'(SEQ_ERR), 8'(tbl[i].se));
         chk($sformatf("r%0d chg", i), CHG_CNT, tbl[i].chg);
         chk($sformatf("r%0d err", i), ERR_CNT, tbl[i].err);
         chk($sformatf("r%0d glitch", i), GLITCH_CNT, tbl[i].gl);
         chk($sformatf("r%0d dout3", i), 8'(DOUT3), 8'(tbl[i].dout3));
         chk($sformatf("r%0d dvalid3", i), 8'(DVALID3), 8'(tbl[i].dv3));
      end

      // Stepping 0,1,...,15,0 including the 15->0 wrap
      do_reset(4'h0);
      p1 = 0;
      p3 = 0;
      se = 0;
      for (int s = 0; s <= 16; s++) begin
         v     = 4'(s % 16);
         ODATA = v;
         repeat (7) begin
            tick();
            if (DVALID) p1++;
            if (DVALID3) p3++;
            if (SEQ_ERR || SEQ_ERR3) se++;
         end
         chk($sformatf("step%0d dout", s), 8'(DOUT), 8'(v));
         chk($sformatf("step%0d dout3", s), 8'(DOUT3), 8'(v));
      end
      chk("step pulses", 8'(p1), 8'd17);
      chk("step pulses3", 8'(p3), 8'd17);
      chk("step seq", 8'(se), 8'd0);
      chk("step chg", CHG_CNT, 8'd16);
      chk("step err", ERR_CNT, 8'd0);
      chk("step chg3 sat", 8'(CHG3), 8'd15);
      chk("step err3", 8'(ERR3), 8'd0);

      // Drive CHG_CNT to saturation, then one more accept
      for (int i = 1; i <= 239; i++) begin
         ODATA = 4'(i % 16);
         repeat (4) begin
            tick();
            if (SEQ_ERR) se++;
         end
      end
      chk("sat chg", CHG_CNT, 8'hFF);
      ODATA = 4'h0;
      p1 = 0;
      repeat (4) begin
         tick();
         if (DVALID) p1++;
         if (SEQ_ERR) se++;
      end
      chk("sat pulse", 8'(p1), 8'd1);
      chk("sat chg hold", CHG_CNT, 8'hFF);
      chk("sat dout", 8'(DOUT), 8'h0);
      chk("sat err", ERR_CNT, 8'd0);
      chk("sat seq", 8'(se), 8'd0);

      // Reset asserted while a candidate (5) is under test
      ODATA = 4'h5;
      tick();
      tick();
      #5;
      RST = 1'b1;
      #1;
      chk("async chg", CHG_CNT, 8'h0);
      chk("async dout", 8'(DOUT), 8'h0);
      tick();
      RST = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk($sformatf("mid e%0d dvalid", e), 8'(DVALID),
             8'(e == 3));
         chk($sformatf("mid e%0d dvalid3", e), 8'(DVALID3),
             8'(e == 4));
         chk($sformatf("mid e%0d seq", e), 8'(SEQ_ERR), 8'h0);
      end
      chk("mid dout", 8'(DOUT), 8'h5);
      chk("mid chg", CHG_CNT, 8'h0);
      chk("mid err", ERR_CNT, 8'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
